// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x DATA_W register file, two combinational read ports,
// one synchronous write port. Register SP_IDX resets to SP_RESET, all others
// reset to zero. Optional write->read bypass is built in when
// REG_FILE_BYPASS_EN is defined; otherwise colliding reads see the old value.

// Single register with its own reset value and write enable.
module reg_file_cell #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Async reset wins over any write on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (we) q <= d;
  end

endmodule

module reg_file_32x32 #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  localparam int unsigned NUM_REGS = 32;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             we;

  // One cell per register; the stack pointer gets its own reset value.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_W-1:0] RV = (i == SP_IDX) ? SP_RESET : '0;

    assign we[i] = reg_write && (wr_addr == 5'(i));

    reg_file_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL (RV)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .we  (we[i]),
      .d   (wr_data),
      .q   (mem[i])
    );
  end

`ifdef REG_FILE_BYPASS_EN
  logic rs_hit, rt_hit;

  // Forward the write-back value to a reader of the same register; held off
  // during reset so outputs track the cleared contents.
  always_comb begin
    rs_hit  = reg_write && !rst && (wr_addr == rs_addr);
    rt_hit  = reg_write && !rst && (wr_addr == rt_addr);
    rs_data = rs_hit ? wr_data : mem[rs_addr];
    rt_data = rt_hit ? wr_data : mem[rt_addr];
  end
`else
  // Plain storage reads; a colliding write shows up after its edge.
  always_comb begin
    rs_data = mem[rs_addr];
    rt_data = mem[rt_addr];
  end
`endif

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

32-entry by 32-bit general-purpose register file for the KGP-RISC single-cycle datapath, with two asynchronous read ports and one synchronous write port. It sits directly downstream of the 5-bit destination-register select mux: that mux's output drives `wr_addr`, and the ALU/memory write-back value drives `wr_data`. Read data feeds the ALU operand path and the store-data path. Reset clears every register except the stack pointer, which loads a configurable initial value.

## Interface
- `DATA_W`, 32, register width in bits
- `SP_IDX`, 29, index of the stack-pointer register
- `SP_RESET`, 32'h0000_0FFC, value loaded into `SP_IDX` on reset
- `clk`  input  1  system clock; all writes occur on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `rs_addr`  input  5  read port A address
- `rt_addr`  input  5  read port B address
- `wr_addr`  input  5  write address, driven by the destination-select mux
- `wr_data`  input  DATA_W  write-back data
- `reg_write`  input  1  write enable, from the control unit
- `rs_data`  output  DATA_W  read port A data
- `rt_data`  output  DATA_W  read port B data

## Operation
- Storage: 32 registers of `DATA_W` bits. All 32 are writable; none is hardwired to zero.
- Reset: while `rst`=1, register `SP_IDX` = `SP_RESET` and every other register = 0. Reset takes effect immediately and does not wait for a clock edge.
- Outputs under reset: follow the cleared contents, so `rs_data` = `rt_data` = 0 unless the address equals `SP_IDX`.
- Write: on a rising edge of `clk` with `rst`=0 and `reg_write`=1, `mem[wr_addr]` <= `wr_data`. When `reg_write`=0, no register changes. Writing `SP_IDX` is legal and overwrites the stack pointer.
- Read: `rs_data` = `mem[rs_addr]` and `rt_data` = `mem[rt_addr]`, both combinational. Both ports may address the same register at the same time, and that register may also be `wr_addr`.
- Same-cycle read/write collision (`reg_write`=1, `wr_addr` = read address): the read result is governed by the Configuration section.
- Deassertion of `rst` coincident with a clock edge: the write on that edge is ignored, and contents remain at their reset values.
- Assertion of `rst` mid-operation: any pending write is discarded and all contents go to their reset values immediately.
- Addresses are exactly 5 bits, so there is no out-of-range case.

## Timing
- Write latency: 1 cycle. Data written on edge N is visible on the read ports immediately after edge N.
- Read latency: 0 cycles (combinational from address and storage).
- With bypass enabled, there is an additional combinational path `wr_data`/`reg_write`/`wr_addr` -> `rs_data`/`rt_data`.
- No handshake. The control unit guarantees that `reg_write` is stable before the rising edge.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- Defined:
  - If `reg_write`=1 and `wr_addr` == `rs_addr`, then `rs_data` = `wr_data` in the same cycle, before the edge. The same rule applies independently to `rt_addr`/`rt_data`.
  - Bypass is suppressed while `rst`=1.
- Undefined:
  - Read ports always return the stored value.
  - A colliding read returns the old value until the write edge, then the new value.

## Test plan
- Reset: assert `rst`, then read all 32 addresses. Expect reg 29 = 32'h0000_0FFC and all others = 0. Assert `rst` asynchronously mid-cycle after writes and expect the same clearing before the next edge.
- Write/read all: write `32'hA5A5_0000 + i` to reg i for i = 0..31, then read pairs (i, 31-i). Expect exact values, including reg 0 = 32'hA5A5_0000 and reg 29 overwritten.
- Write disable: `reg_write`=0, `wr_addr`=5, `wr_data`=32'hDEAD_BEEF for 3 edges. Expect reg 5 unchanged at its prior value, 32'h1234_5678.
- Collision: reg 7 = 32'h1, then `reg_write`=1, `wr_addr`=`rs_addr`=`rt_addr`=7, `wr_data`=32'h2.
  - Before the edge: both ports read 32'h2 with `REG_FILE_BYPASS_EN` defined, or 32'h1 without it.
  - After the edge: both ports read 32'h2 in both builds.
- Reset/edge race: release `rst` coincident with an edge carrying `reg_write`=1, `wr_addr`=3, `wr_data`=32'hFFFF_FFFF. Expect reg 3 = 0. On the following edge the write lands and reg 3 = 32'hFFFF_FFFF.
- Back-to-back writes: consecutive edges write reg 31 = 32'h10 then reg 31 = 32'h20. Expect `rs_data`(31) = 32'h10 after the first edge and 32'h20 after the second.
